// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// A word accepted on load_valid & load_ready is shifted out one bit per
// shift_en cycle. The last-bit cycle can accept the next word directly, so
// back-to-back words stream out with no gap between them.
//
// state | meaning
// IDLE  | no word in flight; load_ready=1, serial outputs held at 0
// SHIFT | word in flight; sout presents the current bit of shreg
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             out_bit;

  // Last bit of the word is consumed this cycle.
  assign last_bit   = (state == SHIFT) && (cnt == LAST) && shift_en;
  assign load_ready = (state == IDLE) || last_bit;

  // The output end of the register depends on the bit order.
  assign out_bit    = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];

  // Serial outputs are decoded from registered state; zero in IDLE.
  assign busy       = (state == SHIFT);
  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) && out_bit;

  // FSM, shift register, bit counter and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= load_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt == LAST) begin
              done <= 1'b1;
              if (load_valid) begin
                shreg <= load_data;
                cnt   <= '0;
              end else begin
                shreg <= '0;
                cnt   <= '0;
                state <= IDLE;
              end
            end else begin
              if (LSB_FIRST != 0) begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
              end else begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
              end
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: scoreboard bench for piso_tx. Two instances (LSB-first and
// MSB-first) share all inputs; accepted words push their bits in the
// expected order into per-instance queues, and the monitor compares the
// front of each queue against sout every cycle.
module tb_piso_tx;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [3:0] load_data;
  logic       shift_en;

  logic ready_l, sout_l, valid_l, busy_l, done_l;
  logic ready_m, sout_m, valid_m, busy_m, done_m;

  int total;
  int bad;

  logic q_l[$];
  logic q_m[$];
  logic q_last[$];
  logic exp_done;

  piso_tx #(.WIDTH(4), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready_l), .shift_en(shift_en), .sout(sout_l),
    .sout_valid(valid_l), .busy(busy_l), .done(done_l)
  );

  piso_tx #(.WIDTH(4), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready_m), .shift_en(shift_en), .sout(sout_m),
    .sout_valid(valid_m), .busy(busy_m), .done(done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic ev, er, nd, lb, tmp;
    if (!rst) begin
      chk("rst_sout_l", sout_l, 0);   chk("rst_sout_m", sout_m, 0);
      chk("rst_valid_l", valid_l, 0); chk("rst_valid_m", valid_m, 0);
      chk("rst_busy_l", busy_l, 0);   chk("rst_busy_m", busy_m, 0);
      chk("rst_done_l", done_l, 0);   chk("rst_done_m", done_m, 0);
      q_l.delete();
      q_m.delete();
      q_last.delete();
      exp_done = 1'b0;
    end else begin
      chk("done_l", done_l, exp_done);
      chk("done_m", done_m, exp_done);
      ev = (q_l.size() > 0);
      chk("valid_l", valid_l, ev);
      chk("valid_m", valid_m, ev);
      chk("busy_l", busy_l, ev);
      chk("busy_m", busy_m, ev);
      chk("sout_l", sout_l, ev ? q_l[0] : 1'b0);
      chk("sout_m", sout_m, ev ? q_m[0] : 1'b0);
      er = !ev || (q_l.size() == 1 && shift_en);
      chk("ready_l", ready_l, er);
      chk("ready_m", ready_m, er);
      nd = 1'b0;
      if (ev && shift_en) begin
        lb  = q_last.pop_front();
        tmp = q_l.pop_front();
        tmp = q_m.pop_front();
        nd  = lb;
      end
      if (load_valid && er) begin
        for (int i = 0; i < 4; i++) begin
          q_l.push_back(load_data[i]);
          q_m.push_back(load_data[3-i]);
          q_last.push_back(i == 3);
        end
      end
      exp_done = nd;
    end
  end

  task automatic step(input logic lv, input logic [3:0] d, input logic se);
    @(posedge clk);
    #1;
    load_valid = lv;
    load_data  = d;
    shift_en   = se;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_done   = 1'b0;
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 4'h0;
    shift_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Single word 4'b1011 with continuous shift_en.
    step(1'b1, 4'hB, 1'b1);
    repeat (4) step(1'b0, 4'h0, 1'b1);
    idle(2);

    // Stalls right after acceptance.
    step(1'b1, 4'hA, 1'b1);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    repeat (4) step(1'b0, 4'h0, 1'b1);
    idle(2);

    // Back-to-back words with load_valid held high.
    step(1'b1, 4'hA, 1'b1);
    repeat (4) step(1'b1, 4'h5, 1'b1);
    repeat (4) step(1'b0, 4'h0, 1'b1);
    idle(2);

    // Load attempt mid-frame must be ignored.
    step(1'b1, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'hF, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    idle(2);

    // Asynchronous reset mid-frame, then a fresh word.
    step(1'b1, 4'hC, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_sout_l", sout_l, 0);   chk("async_sout_m", sout_m, 0);
    chk("async_valid_l", valid_l, 0); chk("async_valid_m", valid_m, 0);
    chk("async_busy_l", busy_l, 0);   chk("async_busy_m", busy_m, 0);
    chk("async_ready_l", ready_l, 1); chk("async_ready_m", ready_m, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    step(1'b1, 4'h3, 1'b1);
    repeat (4) step(1'b0, 4'h0, 1'b1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
